// File: rtl/bcd_pkg.sv
// Shared widths, limits and FSM state type for the BCD-to-binary converter.
package bcd_pkg;
    localparam int DIGIT_W        = 4;
    localparam int ACC_W          = 10;
    localparam int RES_W          = 8;
    localparam int DIGIT_MAX      = 9;
    localparam int UNSIGNED_MAX   = 255;
    localparam int SIGNED_POS_MAX = 127;
    localparam int SIGNED_NEG_MAX = 128;

    typedef enum logic [1:0] {IDLE, ACC, FIN} state_t;
endpackage

// File: rtl/bcd_to_bin_mul10_add.sv
// One accumulation step: acc*10 + digit, with illegal digits contributing zero.
module mul10_add
    import bcd_pkg::*;
(
    input  logic [ACC_W-1:0]   acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [ACC_W-1:0]   acc_nxt,
    output logic               illegal
);
    always_comb begin
        illegal = (digit > DIGIT_W'(DIGIT_MAX));
        acc_nxt = (acc << 3) + (acc << 1) + (illegal ? '0 : ACC_W'(digit));
    end
endmodule

// File: rtl/bcd_to_bin.sv
// Sequential 3-digit BCD to 8-bit binary converter with start/busy/done handshake.
// BCD_SIGN_EN enables signed (two's complement) results driven by the negative input.
module bcd_to_bin
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DIGIT_W-1:0] centenas,
    input  logic [DIGIT_W-1:0] decenas,
    input  logic [DIGIT_W-1:0] unidades,
    input  logic               negative,
    output logic               busy,
    output logic               done,
    output logic [RES_W-1:0]   result,
    output logic               err_digit,
    output logic               err_range
);
    state_t             state;
    logic [1:0]         idx;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_nxt;
    logic [DIGIT_W-1:0] cen_q, dec_q, uni_q;
    logic               neg_q;
    logic               bad;
    logic               illegal;
    logic [DIGIT_W-1:0] digit;
    logic               over;
    logic [RES_W-1:0]   mag;

    always_comb begin
        case (idx)
            2'd0:    digit = cen_q;
            2'd1:    digit = dec_q;
            default: digit = uni_q;
        endcase
    end

    mul10_add u_mul10_add (
        .acc     (acc),
        .digit   (digit),
        .acc_nxt (acc_nxt),
        .illegal (illegal)
    );

`ifdef BCD_SIGN_EN
    // Negative side reaches one further than positive: -128 fits, +128 does not.
    always_comb begin
        over = neg_q ? (acc > ACC_W'(SIGNED_NEG_MAX)) : (acc > ACC_W'(SIGNED_POS_MAX));
        mag  = neg_q ? RES_W'(~acc[RES_W-1:0] + 1'b1) : acc[RES_W-1:0];
    end
`else
    logic unused_neg;
    assign unused_neg = neg_q;

    always_comb begin
        over = (acc > ACC_W'(UNSIGNED_MAX));
        mag  = acc[RES_W-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            err_digit <= 1'b0;
            err_range <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            bad       <= 1'b0;
            cen_q     <= '0;
            dec_q     <= '0;
            uni_q     <= '0;
            neg_q     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cen_q <= centenas;
                        dec_q <= decenas;
                        uni_q <= unidades;
                        neg_q <= negative;
                        acc   <= '0;
                        idx   <= '0;
                        bad   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc_nxt;
                    bad <= bad | illegal;
                    idx <= idx + 2'd1;
                    if (idx == 2'd2) state <= FIN;
                end
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    // An illegal digit masks any range error.
                    if (bad) begin
                        result    <= '0;
                        err_digit <= 1'b1;
                        err_range <= 1'b0;
                    end else if (over) begin
                        result    <= '0;
                        err_digit <= 1'b0;
                        err_range <= 1'b1;
                    end else begin
                        result    <= mag;
                        err_digit <= 1'b0;
                        err_range <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
